// File: rtl/tlul_pkg.sv
// TL-UL opcode constants and A/D channel structs shared by the adapter files.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam int TlDw = 32;
  localparam int TlAw = 32;

  typedef struct packed {
    logic            a_valid;
    logic [2:0]      a_opcode;
    logic [2:0]      a_param;
    logic [1:0]      a_size;
    logic [7:0]      a_source;
    logic [TlAw-1:0] a_address;
    logic [3:0]      a_mask;
    logic [TlDw-1:0] a_data;
    logic            d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic            d_valid;
    logic [2:0]      d_opcode;
    logic [2:0]      d_param;
    logic [1:0]      d_size;
    logic [7:0]      d_source;
    logic            d_sink;
    logic [TlDw-1:0] d_data;
    logic            d_user;
    logic            d_error;
    logic            a_ready;
  } tl_d2h_t;

  // Only the three access opcodes the accelerator understands are legal.
  function automatic logic is_legal_opcode(input logic [2:0] op);
    return (op == Get) || (op == PutFullData) || (op == PutPartialData);
  endfunction

endpackage

// File: rtl/tlul_adapter_err_chk.sv
// Combinational request checker: opcode always, size/alignment/mask when TLUL_ADAPTER_ALIGN_CHECK_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller samples err alongside the A handshake.
module tlul_adapter_err_chk
  import tlul_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic [3:0] mask,
  output logic       err
);

  logic opcode_err;
  logic align_err;

  assign opcode_err = !is_legal_opcode(opcode);

`ifdef TLUL_ADAPTER_ALIGN_CHECK_EN
  // Only full-word, word-aligned accesses with sensible masks reach the accelerator.
  always_comb begin
    align_err = 1'b0;
    if (size != 2'd2)                                 align_err = 1'b1;
    if (addr_lo != 2'b00)                             align_err = 1'b1;
    if ((opcode != PutPartialData) && (mask != 4'hF)) align_err = 1'b1;
    if ((opcode == PutPartialData) && (mask == 4'h0)) align_err = 1'b1;
  end
`else
  logic unused_align;
  assign unused_align = ^{size, addr_lo, mask};
  assign align_err    = 1'b0;
`endif

  assign err = opcode_err | align_err;

endmodule

// File: rtl/tlul_adapter_accel.sv
// TL-UL target adapter driving a strobe register bus into an accelerator (TLUL_ADAPTER_ALIGN_CHECK_EN adds alignment checks).
// Latency: strobe 1 cycle after A handshake, d_valid 2 cycles after (1 for rejected requests), +1 per busy cycle.
// Backpressure: one request outstanding; a_ready only in IDLE, accelerator stalls via busy_i, D held until d_ready.
module tlul_adapter_accel #(
  parameter int RegAw = 8,
  parameter int RegDw = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  tlul_pkg::tl_h2d_t      tl_i,
  output tlul_pkg::tl_d2h_t      tl_o,
  output logic                   re_o,
  output logic                   we_o,
  output logic [RegAw-1:0]       addr_o,
  output logic [RegDw-1:0]       wdata_o,
  output logic [RegDw/8-1:0]     be_o,
  input  logic [RegDw-1:0]       rdata_i,
  input  logic                   busy_i,
  input  logic                   error_i
);
  import tlul_pkg::*;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]         state;
  logic [2:0]         req_op;
  logic [7:0]         req_source;
  logic [1:0]         req_size;
  logic [RegAw-1:0]   req_addr;
  logic [RegDw/8-1:0] req_mask;
  logic [RegDw-1:0]   req_data;
  logic               rsp_err;
  logic [RegDw-1:0]   rsp_data;
  logic               req_bad;
  logic               req_is_get;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[TlAw-1:RegAw]};

  tlul_adapter_err_chk u_err_chk (
    .opcode  (tl_i.a_opcode),
    .size    (tl_i.a_size),
    .addr_lo (tl_i.a_address[1:0]),
    .mask    (tl_i.a_mask),
    .err     (req_bad)
  );

  assign req_is_get = (req_op == Get);

  // Request capture, accelerator completion and response handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      req_op     <= '0;
      req_source <= '0;
      req_size   <= '0;
      req_addr   <= '0;
      req_mask   <= '0;
      req_data   <= '0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tl_i.a_valid) begin
            req_op     <= tl_i.a_opcode;
            req_source <= tl_i.a_source;
            req_size   <= tl_i.a_size;
            req_addr   <= tl_i.a_address[RegAw-1:0];
            req_mask   <= tl_i.a_mask;
            req_data   <= tl_i.a_data;
            rsp_data   <= '0;
            if (req_bad) begin
              rsp_err <= 1'b1;
              state   <= ST_RESP;
            end else begin
              rsp_err <= 1'b0;
              state   <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!busy_i) begin
            rsp_err  <= error_i;
            rsp_data <= (req_is_get && !error_i) ? rdata_i : '0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (tl_i.d_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign re_o    = (state == ST_ACCESS) &&  req_is_get;
  assign we_o    = (state == ST_ACCESS) && !req_is_get;
  assign addr_o  = {req_addr[RegAw-1:2], 2'b00};
  assign wdata_o = req_data;
  assign be_o    = req_mask;

  // D channel is driven only in RESP; a_ready depends on state alone and drops during reset.
  always_comb begin
    tl_o         = '0;
    tl_o.a_ready = (state == ST_IDLE) && !rst_i;
    if (state == ST_RESP) begin
      tl_o.d_valid  = 1'b1;
      tl_o.d_opcode = req_is_get ? AccessAckData : AccessAck;
      tl_o.d_size   = req_size;
      tl_o.d_source = req_source;
      tl_o.d_error  = rsp_err;
      tl_o.d_data   = rsp_data;
    end
  end

endmodule

// File: doc/tlul_adapter_accel.md
# tlul_adapter_accel

Target-side TL-UL adapter that terminates one fan-out port of the main crossbar (e.g. `tl_h2d_accel1` / `tl_d2h_accel1`) and drives a simple register-bus strobe interface into a hardware accelerator. It accepts one request at a time and holds it while the accelerator stalls. It returns exactly one AccessAck/AccessAckData per request, echoing source and size, and flags protocol or target errors on `d_error`.

## Interface
Parameters:
- `RegAw`, default 8: accelerator register address width in bytes; `a_address[RegAw-1:0]` is forwarded.
- `RegDw`, default 32: data width; fixed to the TL-UL bus width of 32.

Ports:
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset, asynchronous, active-high.
- `tl_i`, input, `tlul_pkg::tl_h2d_t`: A-channel request plus `d_ready` from the crossbar.
- `tl_o`, output, `tlul_pkg::tl_d2h_t`: D-channel response plus `a_ready` to the crossbar.
- `re_o`, output, 1: read strobe to the accelerator.
- `we_o`, output, 1: write strobe to the accelerator.
- `addr_o`, output, `RegAw`: word-aligned register address.
- `wdata_o`, output, `RegDw`: write data.
- `be_o`, output, `RegDw/8`: byte enables, equal to `a_mask`.
- `rdata_i`, input, `RegDw`: read data, valid in the completing cycle.
- `busy_i`, input, 1: accelerator stall; the access completes in the first ACCESS cycle with `busy_i`=0.
- `error_i`, input, 1: target error, sampled in the completing cycle.

## Operation
- State machine: IDLE → ACCESS → RESP → IDLE, with a direct IDLE → RESP path for rejected requests.
- **IDLE**
  - `a_ready`=1. This is a function of state only and never depends on `a_valid`.
  - On `a_valid`: register `a_opcode`, `a_source`, `a_size`, `a_address`, `a_mask`, `a_data`.
  - Legal opcodes are Get (4), PutFullData (0) and PutPartialData (1). Any other opcode goes to RESP with a pending error and no strobe.
- **ACCESS**
  - `re_o`=1 for Get; `we_o`=1 for Put. Exactly one of the two is high.
  - `addr_o`, `wdata_o` and `be_o` are stable from the registered copy.
  - Completion: `busy_i`=0 in this cycle. On completion, capture `rdata_i` (Get only) and `error_i`, then go to RESP.
- **RESP**
  - `d_valid`=1.
  - `d_opcode` is AccessAckData (1) for Get and AccessAck (0) otherwise.
  - `d_source` and `d_size` echo the request; `d_param`, `d_sink` and `d_user` are 0.
  - `d_error` is the pending error. `d_data` is the captured data, forced to 0 when `d_error`=1 or when the request was a write.
  - Leave on `d_ready`=1; all D fields stay stable until then.
- Only one request is outstanding at a time; `a_ready` is 0 in ACCESS and in RESP.
- Reset
  - While `rst_i`=1: state IDLE; all outputs are 0, including `a_ready`, `d_valid`, strobes, `addr_o`, `wdata_o`, `be_o` and all D fields.
  - Reset asserted mid-ACCESS or mid-RESP aborts the transaction immediately; no response is issued afterwards.

## Timing
- Request handshake at edge t, with `busy_i`=0:
  - strobe high in cycle t+1;
  - `d_valid` from cycle t+2.
- Each cycle of `busy_i`=1 in ACCESS adds one cycle of latency; the strobes stay high throughout.
- Rejected request: `d_valid` from cycle t+1, and `re_o`/`we_o` never assert.
- D handshake at edge t: `a_ready`=1 in cycle t+1. Peak throughput is one request per 3 cycles.
- A simultaneous `a_valid` and D handshake in RESP is not accepted until IDLE.

## Configuration
- Macro: `TLUL_ADAPTER_ALIGN_CHECK_EN`.
- When defined, a request is rejected with `d_error`=1 (no strobe) if any of these hold:
  - `a_size` is not 2;
  - `a_address[1:0]` is not 0;
  - `a_mask` is not 4'hF for PutFullData or Get;
  - `a_mask` is 0 for PutPartialData.
- When not defined, these checks are absent: any legal opcode proceeds to ACCESS and the low address bits are dropped. Opcode checking is always present.

## Structure
- `tlul_pkg` holds:
  - the opcode constants (`Get`, `PutFullData`, `PutPartialData`, `AccessAck`, `AccessAckData`);
  - the `tl_h2d_t` / `tl_d2h_t` structs.
- The state enum is local to the module.
- Sub-module: `tlul_adapter_err_chk`, a combinational opcode and alignment checker. Its alignment logic is wrapped in `TLUL_ADAPTER_ALIGN_CHECK_EN`.

## Test plan
- Get to 0x10 with `busy_i`=0 and `rdata_i`=32'hCAFE_F00D → `re_o` one cycle at t+1, `addr_o`=8'h10; AccessAckData, data CAFE_F00D, `d_error`=0, source echoed, at t+2.
- PutFullData 32'h1234_5678 to 0x04 with `busy_i` high for 3 cycles → `we_o` held 4 cycles, `wdata_o`=1234_5678, `be_o`=F; AccessAck 4 cycles after the strobe start.
- `a_opcode`=3 → AccessAck with `d_error`=1 at t+1, no strobe, `d_data`=0.
- Get with `error_i`=1 and `d_ready` held low for 5 cycles → `d_valid` and all D fields stable for 5 cycles; `d_error`=1, `d_data`=0; `a_ready`=0 throughout.
- With `TLUL_ADAPTER_ALIGN_CHECK_EN`: Get to 0x06 or with `a_size`=1 → `d_error`=1, no `re_o`. Without the macro → `re_o` with `addr_o`=8'h04.
- Assert `rst_i` during ACCESS → `we_o`, `d_valid` and `a_ready` go to 0 immediately; after release `a_ready`=1 and no stale response appears.
